// File: rtl/div_mae_monitor.sv
// Error monitor for the 16/8 approximate divider row. It recomputes the exact
// result with a restoring divider and accumulates absolute error statistics.
module div_mae_monitor #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      n,
    input  logic [7:0]       d,
    input  logic [7:0]       q_apx,
    input  logic [7:0]       r_apx,
    input  logic             clear,
    output logic             out_valid,
    output logic             skipped,
    output logic [7:0]       err_q,
    output logic [7:0]       err_r,
    output logic [ACC_W-1:0] sum_err_q,
    output logic [ACC_W-1:0] sum_err_r,
    output logic [7:0]       max_err_q,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] skip_cnt,
    output logic             sat
);

    // SKIPW pads the out-of-range path by one cycle so skipped samples keep a 3-cycle cadence
    typedef enum logic [1:0] {IDLE, SKIPW, CALC, UPDATE} state_t;

    state_t      state, state_nx;
    logic [7:0]  n_lo, d_r, qa_r, ra_r;
    logic        skip_r;
    logic [2:0]  step;
    logic [8:0]  rem9, rem_sh, rem_nx;
    logic [7:0]  q_ex;
    logic        hs, oor, ge;
    logic [7:0]  eq, er;

    assign in_ready = (state == IDLE);
    assign hs       = in_valid && in_ready;
    assign oor      = (d == 8'd0) || (n[15:8] >= d);

    assign rem_sh = {rem9[7:0], n_lo[3'd7 - step]};
    assign ge     = (rem_sh >= {1'b0, d_r});
    assign rem_nx = ge ? (rem_sh - {1'b0, d_r}) : rem_sh;

    assign eq = (qa_r >= q_ex) ? (qa_r - q_ex) : (q_ex - qa_r);
    assign er = (ra_r >= rem9[7:0]) ? (ra_r - rem9[7:0]) : (rem9[7:0] - ra_r);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (hs) state_nx = oor ? SKIPW : CALC;
            SKIPW:  state_nx = UPDATE;
            CALC:   if (step == 3'd7) state_nx = UPDATE;
            UPDATE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            n_lo      <= '0;
            d_r       <= '0;
            qa_r      <= '0;
            ra_r      <= '0;
            skip_r    <= 1'b0;
            step      <= '0;
            rem9      <= '0;
            q_ex      <= '0;
            out_valid <= 1'b0;
            skipped   <= 1'b0;
            err_q     <= '0;
            err_r     <= '0;
        end else begin
            state     <= state_nx;
            out_valid <= 1'b0;
            skipped   <= 1'b0;
            case (state)
                IDLE: if (hs) begin
                    n_lo   <= n[7:0];
                    d_r    <= d;
                    qa_r   <= q_apx;
                    ra_r   <= r_apx;
                    skip_r <= oor;
                    step   <= '0;
                    rem9   <= {1'b0, n[15:8]};
                    q_ex   <= '0;
                end
                CALC: begin
                    rem9 <= rem_nx;
                    q_ex <= {q_ex[6:0], ge};
                    step <= step + 3'd1;
                end
                UPDATE: begin
                    out_valid <= 1'b1;
                    skipped   <= skip_r;
                    err_q     <= skip_r ? 8'd0 : eq;
                    err_r     <= skip_r ? 8'd0 : er;
                end
                default: ;
            endcase
        end
    end

    // Saturating statistics; one extra bit on each sum exposes the overflow
    logic [ACC_W:0] sq_w, sr_w;
    logic [CNT_W:0] sc_w, kc_w;
    logic           upd_acc, upd_skip;

    assign upd_acc  = (state == UPDATE) && !skip_r;
    assign upd_skip = (state == UPDATE) && skip_r;
    assign sq_w = {1'b0, sum_err_q} + (ACC_W+1)'(eq);
    assign sr_w = {1'b0, sum_err_r} + (ACC_W+1)'(er);
    assign sc_w = {1'b0, sample_cnt} + (CNT_W+1)'(1);
    assign kc_w = {1'b0, skip_cnt} + (CNT_W+1)'(1);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sum_err_q  <= '0;
            sum_err_r  <= '0;
            max_err_q  <= '0;
            sample_cnt <= '0;
            skip_cnt   <= '0;
            sat        <= 1'b0;
        end else if (upd_acc) begin
            sum_err_q  <= sq_w[ACC_W] ? '1 : sq_w[ACC_W-1:0];
            sum_err_r  <= sr_w[ACC_W] ? '1 : sr_w[ACC_W-1:0];
            sample_cnt <= sc_w[CNT_W] ? '1 : sc_w[CNT_W-1:0];
            if (eq > max_err_q) max_err_q <= eq;
            if (sq_w[ACC_W] || sr_w[ACC_W] || sc_w[CNT_W]) sat <= 1'b1;
        end else if (upd_skip) begin
            skip_cnt <= kc_w[CNT_W] ? '1 : kc_w[CNT_W-1:0];
            if (kc_w[CNT_W]) sat <= 1'b1;
        end
    end

endmodule
